// File: rtl/rps_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rps_pkg
//  Description : Shared types and constants for the rock-paper-scissors
//                player driver: move encoding, player FSM states, LFSR
//                feedback mask and a move-to-one-hot helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package rps_pkg;

  // Galois feedback taps for a maximal-length 16-bit LFSR
  localparam logic [15:0] LFSR_MASK = 16'hB400;

  typedef enum logic [1:0] {
    MOVE_R = 2'd0,
    MOVE_P = 2'd1,
    MOVE_S = 2'd2
  } rps_move_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PICK  = 3'd1,
    ARMED = 3'd2,
    GAP   = 3'd3,
    DONE  = 3'd4
  } player_state_e;

  // One-hot ordering is {r, p, s}
  function automatic logic [2:0] move_to_onehot(input rps_move_e m);
    logic [2:0] oh;
    oh = 3'b000;
    case (m)
      MOVE_R:  oh = 3'b100;
      MOVE_P:  oh = 3'b010;
      MOVE_S:  oh = 3'b001;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rps_lfsr.sv
`default_nettype none
// ============================================================================
//  Module      : rps_lfsr
//  Description : Right-shifting Galois LFSR with an advance enable.
//                Ports: clk, rst (async, active-low), advance (step one
//                position this cycle), value (current register contents).
//  Revision    : 1.0 - initial release
// ============================================================================
module rps_lfsr #(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] MASK  = 16'hB400,
  parameter logic [WIDTH-1:0] SEED  = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             advance,
  output logic [WIDTH-1:0] value
);

  logic [WIDTH-1:0] value_q;
  logic [WIDTH-1:0] value_d;

  always_comb begin
    value_d = value_q;
    if (advance) begin
      value_d = (value_q >> 1) ^ (value_q[0] ? MASK : {WIDTH{1'b0}});
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      value_q <= SEED;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule
`default_nettype wire

// File: rtl/rps_player.sv
`default_nettype none
// ============================================================================
//  Module      : rps_player
//  Description : Player-side driver for the rock-paper-scissors arbitrator
//                handshake. Picks a pseudo-random one-hot move, raises go
//                until the arbitrator acknowledges with dut_busy, idles for
//                GAP_CYCLES, and repeats for NUM_ROUNDS rounds.
//  Ports       : clk, rst (async assert, active-low), start, dut_busy  (in)
//                r, p, s, go, active, done, rounds_played[15:0]        (out)
//                cnt_r, cnt_p, cnt_s[15:0] (out, only with
//                RPS_PLAYER_HISTORY_EN defined: per-move acknowledge counts)
//  Config      : `define RPS_PLAYER_HISTORY_EN to add the move-history
//                counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module rps_player
  import rps_pkg::*;
#(
  parameter int          NUM_ROUNDS = 16,
  parameter int          GAP_CYCLES = 2,
  parameter logic [15:0] SEED       = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,            // active-low
  input  logic        start,
  input  logic        dut_busy,
  output logic        r,
  output logic        p,
  output logic        s,
  output logic        go,
  output logic        active,
  output logic        done,
  output logic [15:0] rounds_played
`ifdef RPS_PLAYER_HISTORY_EN
  ,
  output logic [15:0] cnt_r,
  output logic [15:0] cnt_p,
  output logic [15:0] cnt_s
`endif
);

  generate
    if (SEED == 16'h0000) begin : g_seed_check
      $error("rps_player: SEED must be non-zero");
    end
    if (NUM_ROUNDS < 1 || NUM_ROUNDS > 65535 || GAP_CYCLES < 0 || GAP_CYCLES > 255) begin : g_range_check
      $error("rps_player: NUM_ROUNDS or GAP_CYCLES out of range");
    end
  endgenerate

  player_state_e state_q, state_d;
  logic [2:0]    move_q, move_d;      // {r, p, s}
  logic [15:0]   rounds_q, rounds_d;
  logic [7:0]    gap_q, gap_d;
  logic [15:0]   rounds_inc;
  logic          lfsr_adv;
  logic [15:0]   lfsr_val;
  logic          round_ack;           // acknowledge edge for this round
  logic          match_clr;           // new match begins this edge
  logic          unused_lfsr_hi;

  rps_lfsr #(
    .WIDTH (16),
    .MASK  (LFSR_MASK),
    .SEED  (SEED)
  ) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .advance (lfsr_adv),
    .value   (lfsr_val)
  );

  assign unused_lfsr_hi = ^lfsr_val[15:2];
  assign rounds_inc     = rounds_q + 16'd1;

  always_comb begin
    state_d   = state_q;
    move_d    = move_q;
    rounds_d  = rounds_q;
    gap_d     = gap_q;
    lfsr_adv  = 1'b0;
    go        = 1'b0;
    round_ack = 1'b0;
    match_clr = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d   = PICK;
          rounds_d  = 16'd0;
          match_clr = 1'b1;
        end
      end
      PICK: begin
        // Candidate comes from the pre-advance value; 3 is not a move, so redraw.
        lfsr_adv = 1'b1;
        if (lfsr_val[1:0] != 2'd3) begin
          move_d  = move_to_onehot(rps_move_e'(lfsr_val[1:0]));
          state_d = ARMED;
        end
      end
      ARMED: begin
        // Combinational drop so the arbitrator never sees go on a second edge.
        go = ~dut_busy;
        if (dut_busy) begin
          round_ack = 1'b1;
          rounds_d  = rounds_inc;
          if (rounds_inc == 16'(NUM_ROUNDS)) begin
            state_d = DONE;
          end else if (GAP_CYCLES == 0) begin
            state_d = PICK;
          end else begin
            state_d = GAP;
            gap_d   = 8'(GAP_CYCLES);
          end
        end
      end
      GAP: begin
        gap_d = gap_q - 8'd1;
        if (gap_q <= 8'd1) begin
          state_d = PICK;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      move_q   <= 3'b000;
      rounds_q <= 16'd0;
      gap_q    <= 8'd0;
    end else begin
      state_q  <= state_d;
      move_q   <= move_d;
      rounds_q <= rounds_d;
      gap_q    <= gap_d;
    end
  end

  assign r             = move_q[2];
  assign p             = move_q[1];
  assign s             = move_q[0];
  assign active        = (state_q == PICK) || (state_q == ARMED) || (state_q == GAP);
  assign done          = (state_q == DONE);
  assign rounds_played = rounds_q;

`ifdef RPS_PLAYER_HISTORY_EN
  logic [15:0] cnt_r_q, cnt_r_d;
  logic [15:0] cnt_p_q, cnt_p_d;
  logic [15:0] cnt_s_q, cnt_s_d;

  always_comb begin
    cnt_r_d = cnt_r_q;
    cnt_p_d = cnt_p_q;
    cnt_s_d = cnt_s_q;
    if (match_clr) begin
      cnt_r_d = 16'd0;
      cnt_p_d = 16'd0;
      cnt_s_d = 16'd0;
    end else if (round_ack) begin
      cnt_r_d = cnt_r_q + {15'd0, move_q[2]};
      cnt_p_d = cnt_p_q + {15'd0, move_q[1]};
      cnt_s_d = cnt_s_q + {15'd0, move_q[0]};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r_q <= 16'd0;
      cnt_p_q <= 16'd0;
      cnt_s_q <= 16'd0;
    end else begin
      cnt_r_q <= cnt_r_d;
      cnt_p_q <= cnt_p_d;
      cnt_s_q <= cnt_s_d;
    end
  end

  assign cnt_r = cnt_r_q;
  assign cnt_p = cnt_p_q;
  assign cnt_s = cnt_s_q;
`else
  logic unused_hist;
  assign unused_hist = round_ack ^ match_clr;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rps_player.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_rps_player
//  Description : Directed, scoreboard-checked bench for rps_player. Two
//                instances: A (3 rounds, gap 2) and B (64 rounds, gap 0).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rps_player;

  localparam logic [15:0] SEED  = 16'hACE1;
  localparam int          N_A   = 3;
  localparam int          GAP_A = 2;
  localparam int          N_B   = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start_a, start_b, busy_a, busy_b;
  logic        r_a, p_a, s_a, go_a, act_a, done_a;
  logic        r_b, p_b, s_b, go_b, act_b, done_b;
  logic [15:0] rnd_a, rnd_b;
`ifdef RPS_PLAYER_HISTORY_EN
  logic [15:0] cr_a, cp_a, cs_a, cr_b, cp_b, cs_b;
`endif

  rps_player #(.NUM_ROUNDS(N_A), .GAP_CYCLES(GAP_A), .SEED(SEED)) u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .dut_busy(busy_a),
    .r(r_a), .p(p_a), .s(s_a), .go(go_a), .active(act_a), .done(done_a),
    .rounds_played(rnd_a)
`ifdef RPS_PLAYER_HISTORY_EN
    , .cnt_r(cr_a), .cnt_p(cp_a), .cnt_s(cs_a)
`endif
  );

  rps_player #(.NUM_ROUNDS(N_B), .GAP_CYCLES(0), .SEED(SEED)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .dut_busy(busy_b),
    .r(r_b), .p(p_b), .s(s_b), .go(go_b), .active(act_b), .done(done_b),
    .rounds_played(rnd_b)
`ifdef RPS_PLAYER_HISTORY_EN
    , .cnt_r(cr_b), .cnt_p(cp_b), .cnt_s(cs_b)
`endif
  );

  typedef struct {
    logic [2:0] oh;
    int         steps;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] mdl_lfsr [2];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          exp_rounds;
  int          hist [3];
  logic [2:0]  first_seq [N_A];

  // Software reference: Galois LFSR, mask B400, redraw on candidate 3.
  function automatic exp_t gen_move(input int w);
    exp_t       e;
    logic [1:0] c;
    e.steps = 0;
    c       = 2'd3;
    while (c == 2'd3 && e.steps < 64) begin
      c           = mdl_lfsr[w][1:0];
      mdl_lfsr[w] = {1'b0, mdl_lfsr[w][15:1]} ^ (mdl_lfsr[w][0] ? 16'hB400 : 16'h0000);
      e.steps++;
    end
    e.oh = (c == 2'd0) ? 3'b100 : (c == 2'd1) ? 3'b010 : 3'b001;
    return e;
  endfunction

  function automatic logic [2:0] mv_of(input int w);
    return (w == 0) ? {r_a, p_a, s_a} : {r_b, p_b, s_b};
  endfunction
  function automatic logic go_of(input int w);
    return (w == 0) ? go_a : go_b;
  endfunction
  function automatic logic [15:0] rnd_of(input int w);
    return (w == 0) ? rnd_a : rnd_b;
  endfunction
  function automatic logic [5:0] flags_of(input int w);
    return (w == 0) ? {r_a, p_a, s_a, go_a, act_a, done_a} : {r_b, p_b, s_b, go_b, act_b, done_b};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_busy(input int w, input logic v);
    if (w == 0) busy_a = v;
    else        busy_b = v;
  endtask

  task automatic push_match(input int w, input int n);
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(gen_move(w));
    exp_rounds = 0;
    hist[0] = 0; hist[1] = 0; hist[2] = 0;
  endtask

  task automatic start_pulse(input int w);
    if (w == 0) start_a = 1'b1; else start_b = 1'b1;
    tick();
    if (w == 0) start_a = 1'b0; else start_b = 1'b0;
  endtask

  // One round: wait for go, compare against the scoreboard, optionally stall
  // the acknowledge, then score on one edge and raise dut_busy the next.
  task automatic play_round(input int w, input int gap, input int hold, output logic [2:0] got);
    exp_t       e;
    int         n;
    logic [2:0] mv0;
    logic [15:0] r0;
    int         bad;
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
      got = 3'b000;
      return;
    end
    e = exp_q.pop_front();
    n = 0;
    while (go_of(w) !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    chk("go_rise_latency", n, gap + e.steps);
    chk("move", {29'd0, mv_of(w)}, {29'd0, e.oh});
    got = mv_of(w);
    mv0 = mv_of(w);
    r0  = rnd_of(w);
    bad = 0;
    for (int i = 0; i < hold; i++) begin
      tick();
      if (go_of(w) !== 1'b1 || mv_of(w) !== mv0 || rnd_of(w) !== r0) bad++;
    end
    if (hold > 0) chk("stall_hold_bad_cycles", bad, 0);
    tick();
    set_busy(w, 1'b1);
    #1;
    chk("go_drop_on_busy", {31'd0, go_of(w)}, 32'd0);
    tick();
    set_busy(w, 1'b0);
    exp_rounds++;
    if (e.oh == 3'b100) hist[0]++;
    else if (e.oh == 3'b010) hist[1]++;
    else hist[2]++;
    chk("rounds_played", {16'd0, rnd_of(w)}, exp_rounds);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] got;
    int         bad;
    rst = 1'b0; start_a = 1'b0; start_b = 1'b0; busy_a = 1'b0; busy_b = 1'b0;
    mdl_lfsr[0] = SEED; mdl_lfsr[1] = SEED;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    chk("reset_flags_a", {26'd0, flags_of(0)}, 32'd0);
    chk("reset_rounds_a", {16'd0, rnd_a}, 32'd0);
    chk("reset_flags_b", {26'd0, flags_of(1)}, 32'd0);

    // Match 1 on A: three rounds, gap of two between them
    push_match(0, N_A);
    start_pulse(0);
    chk("active_after_start", {31'd0, act_a}, 32'd1);
    for (int i = 0; i < N_A; i++) begin
      play_round(0, (i == 0) ? 0 : GAP_A, 0, got);
      first_seq[i] = got;
    end
    chk("done_after_match", {29'd0, done_a, act_a, go_a}, 32'b100);
    chk("rounds_final", {16'd0, rnd_a}, N_A);
`ifdef RPS_PLAYER_HISTORY_EN
    chk("hist_sum_a", cr_a + cp_a + cs_a, N_A);
    chk("hist_r_a", {16'd0, cr_a}, hist[0]);
`endif

    // Acknowledge outside ARMED must be ignored
    busy_a = 1'b1;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (go_a !== 1'b0 || done_a !== 1'b1 || rnd_a !== 16'(N_A)) bad++;
    end
    busy_a = 1'b0;
    chk("busy_ignored_in_done", bad, 0);

    // Match 2 on A from DONE (no reseed); stall the first acknowledge
    push_match(0, N_A);
    start_pulse(0);
    chk("restart_rounds_cleared", {16'd0, rnd_a}, 32'd0);
    play_round(0, 0, 50, got);

    // Now in GAP: asynchronous reset between edges
    #3;
    rst = 1'b0;
    #1;
    chk("async_reset_flags", {26'd0, flags_of(0)}, 32'd0);
    chk("async_reset_rounds", {16'd0, rnd_a}, 32'd0);
    tick();
    tick();
    rst = 1'b1;
    mdl_lfsr[0] = SEED; mdl_lfsr[1] = SEED;
    tick();
    chk("idle_after_reset", {26'd0, flags_of(0)}, 32'd0);

    // Restart must replay the first match
    push_match(0, N_A);
    bad = 0;
    for (int i = 0; i < N_A; i++) if (exp_q[i].oh !== first_seq[i]) bad++;
    chk("replay_model_seq", bad, 0);
    start_pulse(0);
    bad = 0;
    for (int i = 0; i < N_A; i++) begin
      play_round(0, (i == 0) ? 0 : GAP_A, 0, got);
      if (got !== first_seq[i]) bad++;
    end
    chk("replay_dut_seq", bad, 0);
    chk("done_after_replay", {31'd0, done_a}, 32'd1);

    // B: 64 rounds, no gap; start held high during round 2 must be ignored
    push_match(1, N_B);
    start_pulse(1);
    for (int i = 0; i < N_B; i++) begin
      if (i == 1) start_b = 1'b1;
      play_round(1, 0, 0, got);
      if (i == 1) start_b = 1'b0;
    end
    chk("done_b", {29'd0, done_b, act_b, go_b}, 32'b100);
    chk("rounds_b", {16'd0, rnd_b}, N_B);
`ifdef RPS_PLAYER_HISTORY_EN
    chk("hist_sum_b", cr_b + cp_b + cs_b, N_B);
    chk("hist_r_b", {16'd0, cr_b}, hist[0]);
    chk("hist_p_b", {16'd0, cp_b}, hist[1]);
    chk("hist_s_b", {16'd0, cs_b}, hist[2]);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
